mc_alu: RTL and testbench

MC_ALU -- requirements
Module: mc_alu

---
 rtl/mc_alu.sv | 164 ++++++++++++++++
 tb/tb_mc_alu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU.
// AND/OR/ADD/SUB (and unlisted codes treated as AND) finish in one cycle and
// can be issued back to back. MUL is a fixed-latency shift-and-add that
// takes MUL_CYCLES iterations, with no early exit.
// data_o and Zero_o are registered and hold until the next result.
// valid_o pulses for one cycle when a new result appears.
module mc_alu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o,
    output logic             valid_o,
    output logic             busy_o
);

    // Counter is wide enough to hold MUL_CYCLES-1 for any legal parameter.
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             valid_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             accept;
    logic             is_mul;
    logic             last_iter;
    logic [WIDTH-1:0] and_vec;
    logic [WIDTH-1:0] or_vec;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] acc_next;

    // Start is only honoured in IDLE, so a request during MUL_RUN leaves no trace.
    assign accept    = (state_reg == IDLE) && start_i;
    assign is_mul    = (ALUCtrl_i == OP_MUL);
    assign last_iter = (state_reg == MUL_RUN) && (cnt_reg == CNT_W'(MUL_CYCLES - 1));

    // The bitwise terms are built per bit.
    // The multiplicand is gated per bit by the current multiplier LSB.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign and_vec[gi] = data1_i[gi] & data2_i[gi];
            assign or_vec[gi]  = data1_i[gi] | data2_i[gi];
            assign addend[gi]  = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    // This is the accumulator value after the current iteration. The last
    // iteration writes it straight to the result, so that iteration is counted.
    assign acc_next = acc_reg + addend;

    // Single-cycle result. Any code that is not listed falls back to AND.
    always_comb begin
        alu_result = and_vec;
        case (ALUCtrl_i)
            OP_AND:  alu_result = and_vec;
            OP_OR:   alu_result = or_vec;
            OP_ADD:  alu_result = data1_i + data2_i;
            OP_SUB:  alu_result = data1_i - data2_i;
            default: alu_result = and_vec;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: MUL moves to MUL_RUN, and the last iteration returns to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_i && is_mul) begin
                    state_next = MUL_RUN;
                end
            end
            MUL_RUN: begin
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: busy_o is high for the whole of MUL_RUN.
    always_comb begin
        busy_o = 1'b0;
        if (state_reg == MUL_RUN) begin
            busy_o = 1'b1;
        end
    end

    // Datapath: result capture, the valid pulse and the shift-and-add iterations.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_reg <= '0;
            zero_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else begin
            valid_reg <= 1'b0;
            if (accept) begin
                if (is_mul) begin
                    mcand_reg  <= data1_i;
                    mplier_reg <= data2_i;
                    acc_reg    <= '0;
                    cnt_reg    <= '0;
                end else begin
                    result_reg <= alu_result;
                    zero_reg   <= (alu_result == '0);
                    valid_reg  <= 1'b1;
                end
            end else if (state_reg == MUL_RUN) begin
                acc_reg    <= acc_next;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + CNT_W'(1);
                if (last_iter) begin
                    result_reg <= acc_next;
                    zero_reg   <= (acc_next == '0);
                    valid_reg  <= 1'b1;
                end
            end
        end
    end

    assign data_o  = result_reg;
    assign Zero_o  = zero_reg;
    assign valid_o = valid_reg;

endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: directed, table-driven bench for mc_alu.
// It also has hand-written sequences for the MUL timing corners.
module tb_mc_alu;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  ALUCtrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [31:0] data_o;
    logic        Zero_o;
    logic        valid_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    mc_alu #(.WIDTH(32), .MUL_CYCLES(32)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .data_o    (data_o),
        .Zero_o    (Zero_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_d;
        logic        exp_z;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Waits one edge, then samples 1 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issues a MUL and can inject an ADD 1+1 request before a chosen edge.
    // It checks latency, busy length, the result and the valid pulse width.
    // It returns in the valid cycle, so the caller can issue a request there.
    task automatic mul_run(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input logic exp_z,
                           input int inject_at, input string name);
        int lat;
        int busy_cnt;
        logic [31:0] got_d;
        logic        got_z;
        logic        got_busy;
        lat      = 0;
        busy_cnt = 0;
        got_d    = '0;
        got_z    = 1'b0;
        got_busy = 1'b0;
        ALUCtrl_i = 3'b111;
        data1_i   = a;
        data2_i   = b;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        if (busy_o) busy_cnt++;
        for (int n = 1; n <= 40; n++) begin
            if (n == inject_at) begin
                start_i   = 1'b1;
                ALUCtrl_i = 3'b010;
                data1_i   = 32'd1;
                data2_i   = 32'd1;
            end
            tick();
            start_i = 1'b0;
            if (valid_o) begin
                lat      = n;
                got_d    = data_o;
                got_z    = Zero_o;
                got_busy = busy_o;
                break;
            end
            if (busy_o) busy_cnt++;
        end
        $display("mul %s: a=0x%08h b=0x%08h data_o=0x%08h Zero_o=%0b latency=%0d busy=%0d",
                 name, a, b, got_d, got_z, lat, busy_cnt);
        check({name, " latency"}, lat, 32);
        check({name, " busy_cycles"}, busy_cnt, 32);
        check({name, " data"}, got_d, exp_d);
        check({name, " zero"}, {31'd0, got_z}, {31'd0, exp_z});
        check({name, " busy_at_valid"}, {31'd0, got_busy}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{3'b010, 32'd7,         32'd5,         32'd12,        1'b0};
        vecs[1]  = '{3'b110, 32'd5,         32'd5,         32'd0,         1'b1};
        vecs[2]  = '{3'b001, 32'h000000F0,  32'h0000000F,  32'h000000FF,  1'b0};
        vecs[3]  = '{3'b000, 32'hFF00FF00,  32'h0FF00FF0,  32'h0F000F00,  1'b0};
        vecs[4]  = '{3'b010, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1};
        vecs[5]  = '{3'b110, 32'd0,         32'd1,         32'hFFFFFFFF,  1'b0};
        vecs[6]  = '{3'b011, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b0};
        vecs[7]  = '{3'b100, 32'hAAAA5555,  32'hFFFF0000,  32'hAAAA0000,  1'b0};
        vecs[8]  = '{3'b101, 32'h12345678,  32'd0,         32'd0,         1'b1};
        vecs[9]  = '{3'b001, 32'd0,         32'd0,         32'd0,         1'b1};
        vecs[10] = '{3'b110, 32'd3,         32'd5,         32'hFFFFFFFE,  1'b0};

        rst_i     = 1'b1;
        start_i   = 1'b1;
        ALUCtrl_i = 3'b010;
        data1_i   = 32'd9;
        data2_i   = 32'd9;
        repeat (3) tick();
        $display("reset: data_o=0x%08h Zero_o=%0b valid_o=%0b busy_o=%0b", data_o, Zero_o, valid_o, busy_o);
        check("reset data", data_o, 32'd0);
        check("reset zero", {31'd0, Zero_o}, 32'd0);
        check("reset valid", {31'd0, valid_o}, 32'd0);
        check("reset busy", {31'd0, busy_o}, 32'd0);

        // Single-cycle ops are issued back to back. The first one is accepted on the edge right after reset is released.
        rst_i = 1'b0;
        for (int i = 0; i < 11; i++) begin
            ALUCtrl_i = vecs[i].op;
            data1_i   = vecs[i].a;
            data2_i   = vecs[i].b;
            start_i   = 1'b1;
            tick();
            $display("vec %0d: op=%03b a=0x%08h b=0x%08h data_o=0x%08h Zero_o=%0b valid_o=%0b",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, data_o, Zero_o, valid_o);
            check($sformatf("vec%0d data", i), data_o, vecs[i].exp_d);
            check($sformatf("vec%0d zero", i), {31'd0, Zero_o}, {31'd0, vecs[i].exp_z});
            check($sformatf("vec%0d valid", i), {31'd0, valid_o}, 32'd1);
        end
        start_i = 1'b0;
        tick();
        $display("idle: data_o=0x%08h valid_o=%0b", data_o, valid_o);
        check("idle valid", {31'd0, valid_o}, 32'd0);
        check("idle hold data", data_o, 32'hFFFFFFFE);

        // MUL runs with fixed latency, including wraparound and zero operands.
        mul_run(32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 0, "mul_ffff");
        tick();
        check("mul_ffff pulse_end", {31'd0, valid_o}, 32'd0);
        check("mul_ffff hold", data_o, 32'hFFFFFFFF);
        mul_run(32'h80000000, 32'd2, 32'd0, 1'b1, 0, "mul_wrap");
        mul_run(32'd0, 32'hFFFFFFFF, 32'd0, 1'b1, 0, "mul_zero");

        // An ADD request made during MUL_RUN must be ignored.
        mul_run(32'd6, 32'd7, 32'd42, 1'b0, 10, "mul_ignore");
        // A request is accepted in the MUL's valid cycle.
        ALUCtrl_i = 3'b010;
        data1_i   = 32'd2;
        data2_i   = 32'd2;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        $display("after mul: add 2+2 data_o=0x%08h valid_o=%0b", data_o, valid_o);
        check("post_mul add data", data_o, 32'd4);
        check("post_mul add valid", {31'd0, valid_o}, 32'd1);
        tick();

        // Reset aborts an in-progress MUL.
        ALUCtrl_i = 3'b111;
        data1_i   = 32'd6;
        data2_i   = 32'd7;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (15) tick();
        check("abort busy_before", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        $display("abort: data_o=0x%08h Zero_o=%0b valid_o=%0b busy_o=%0b", data_o, Zero_o, valid_o, busy_o);
        check("abort data", data_o, 32'd0);
        check("abort zero", {31'd0, Zero_o}, 32'd0);
        check("abort valid", {31'd0, valid_o}, 32'd0);
        check("abort busy", {31'd0, busy_o}, 32'd0);
        begin
            int vseen;
            vseen = 0;
            for (int n = 0; n < 20; n++) begin
                tick();
                if (valid_o || busy_o) vseen++;
            end
            check("abort no_activity", vseen, 0);
        end
        ALUCtrl_i = 3'b010;
        data1_i   = 32'd2;
        data2_i   = 32'd3;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        $display("post reset: add 2+3 data_o=0x%08h valid_o=%0b", data_o, valid_o);
        check("post_rst add data", data_o, 32'd5);
        check("post_rst add valid", {31'd0, valid_o}, 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
